// File: rtl/branch_inst_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_enc_pkg
// Brief  : Shared types and constants for the RV32I branch/jump encoder.
// Rev    : 1.0
// ============================================================================
package rv_enc_pkg;

  typedef enum logic [2:0] {
    ENC_B = 3'b000,
    ENC_J = 3'b001
  } enc_type_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_TYPE  = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_RANGE = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam int B_MIN_OFF = -4096;
  localparam int B_MAX_OFF = 4094;
  localparam int J_MIN_OFF = -1048576;
  localparam int J_MAX_OFF = 1048574;

  typedef struct packed {
    logic [2:0]  enc_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } enc_req_t;

endpackage
`default_nettype wire

// File: rtl/branch_inst_encoder_if.sv
`default_nettype none
// ============================================================================
// Module : branch_inst_encoder_if
// Brief  : Request, run-control and instruction-memory write bundle.
// Rev    : 1.0
// ============================================================================
interface branch_inst_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_enc_type;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   wr_count;

  modport master (
    output start, finish, in_valid, in_enc_type, in_rs1, in_rs2, in_rd,
           in_funct3, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err,
           err_code, wr_count
  );

  modport slave (
    input  start, finish, in_valid, in_enc_type, in_rs1, in_rs2, in_rd,
           in_funct3, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err,
           err_code, wr_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_inst_encoder_imm_pack.sv
`default_nettype none
// ============================================================================
// Module : rv_imm_pack
// Brief  : Combinational legality check and B/J-type bit packing.
// Rev    : 1.0
// ============================================================================
module rv_imm_pack
  import rv_enc_pkg::*;
(
  input  enc_req_t    i_req,
  output logic [31:0] o_word,
  output err_code_e   o_err_code
);

  logic signed [31:0] w_imm_s;
  logic               w_in_range;
  logic               w_type_ok;

  always_comb begin
    w_imm_s    = $signed(i_req.imm);
    w_in_range = 1'b0;
    w_type_ok  = 1'b0;
    o_word     = '0;
    o_err_code = ERR_NONE;

    case (i_req.enc_type)
      ENC_B: begin
        w_type_ok  = 1'b1;
        w_in_range = (w_imm_s >= B_MIN_OFF) && (w_imm_s <= B_MAX_OFF);
        o_word     = {i_req.imm[12], i_req.imm[10:5], i_req.rs2, i_req.rs1,
                      i_req.funct3, i_req.imm[4:1], i_req.imm[11], OPC_BRANCH};
      end
      ENC_J: begin
        w_type_ok  = 1'b1;
        w_in_range = (w_imm_s >= J_MIN_OFF) && (w_imm_s <= J_MAX_OFF);
        o_word     = {i_req.imm[20], i_req.imm[10:1], i_req.imm[11],
                      i_req.imm[19:12], i_req.rd, OPC_JAL};
      end
      default: ;
    endcase

    // Priority: type, then alignment, then range.
    if (!w_type_ok) begin
      o_err_code = ERR_TYPE;
    end else if (i_req.imm[0]) begin
      o_err_code = ERR_ALIGN;
    end else if (!w_in_range) begin
      o_err_code = ERR_RANGE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module : branch_inst_encoder
// Brief  : Packs branch/jump requests into RV32I words and streams legal ones
//          into instruction memory through a two-stage pipeline.
// Rev    : 1.0
// ============================================================================
module branch_inst_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  branch_inst_encoder_if.slave  bus
);

  localparam logic [ADDR_W:0] C_CAP = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              s1_valid_q, s1_valid_d;
  enc_req_t          s1_req_q, s1_req_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  err_code_e         err_code_q, err_code_d;
  logic [ADDR_W:0]   wr_count_q, wr_count_d;

  logic              w_in_ready;
  logic              w_accept;
  enc_req_t          w_in_req;
  logic [31:0]       w_word;
  err_code_e         w_pack_err;

  rv_imm_pack u_pack (
    .i_req      (s1_req_q),
    .o_word     (w_word),
    .o_err_code (w_pack_err)
  );

  always_comb begin
    w_in_ready = (state_q == ST_RUN) && (acc_cnt_q < C_CAP);
    w_accept   = bus.in_valid && w_in_ready;
    w_in_req   = '{enc_type: bus.in_enc_type, rs1: bus.in_rs1, rs2: bus.in_rs2,
                   rd: bus.in_rd, funct3: bus.in_funct3, imm: bus.in_imm};

    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    s1_valid_d   = w_accept;
    s1_req_d     = w_accept ? w_in_req : s1_req_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    wr_count_d   = wr_count_q;

    if (w_accept) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end

    // Second stage: commit the checked word or record the first rejection.
    if (s1_valid_q) begin
      if (w_pack_err == ERR_NONE) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = wr_ptr_q;
        imem_wdata_d = w_word;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        wr_count_d   = wr_count_q + 1'b1;
      end else begin
        err_d = 1'b1;
        if (!err_q) begin
          err_code_d = w_pack_err;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_RUN;
          wr_ptr_d   = ADDR_W'(BASE_ADDR);
          acc_cnt_d  = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          wr_count_d = '0;
        end
      end
      ST_RUN: begin
        if (bus.finish || (acc_cnt_d == C_CAP)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!s1_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      acc_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_req_q     <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      s1_valid_q   <= s1_valid_d;
      s1_req_q     <= s1_req_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
  assign bus.wr_count   = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_inst_encoder
// Brief  : Directed and randomized checks of branch_inst_encoder against a
//          decode-side reference model.
// Rev    : 1.0
// ============================================================================
module tb_branch_inst_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  branch_inst_encoder_if #(.ADDR_W(8)) bus ();
  branch_inst_encoder_if #(.ADDR_W(2)) bus2 ();

  branch_inst_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_inst_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  typedef struct {
    logic [2:0]  t;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [7:0]  addr;
    int          due;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_ptr = 8'd0;
  int         m_err = 0;
  int         m_code = 0;
  int         m_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Rule-level legality: 0 ok, 1 bad type, 2 odd offset, 3 out of range.
  function automatic int classify(input logic [2:0] t, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    if (t > 3'd1) return 1;
    if (imm[0]) return 2;
    if (t == 3'd0 && (v < -4096 || v > 4094)) return 3;
    if (t == 3'd1 && (v < -1048576 || v > 1048574)) return 3;
    return 0;
  endfunction

  // Scoreboard: decode every written word and compare with the request.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] w;
    logic [31:0] dimm;
    logic [19:0] fields;
    logic [19:0] expf;
    int          code;
    if (rst) begin
      q.delete();
    end else begin
      if (bus.imem_we) begin
        chk("we_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          w = bus.imem_wdata;
          chk("we_latency", cyc, e.due);
          chk("we_addr", 32'(bus.imem_addr), 32'(e.addr));
          if (e.t == 3'd0) begin
            dimm   = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            fields = {w[6:0], w[24:20], w[19:15], w[14:12]};
            expf   = {7'b1100011, e.rs2, e.rs1, e.f3};
          end else begin
            dimm   = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            fields = {w[6:0], w[11:7], 8'h00};
            expf   = {7'b1101111, e.rd, 8'h00};
          end
          chk("dec_imm", dimm, e.imm);
          chk("dec_fields", 32'(fields), 32'(expf));
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        chk("we_missing", 32'(bus.imem_we), 32'd1);
        void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        code = classify(bus.in_enc_type, bus.in_imm);
        if (code == 0) begin
          q.push_back('{t: bus.in_enc_type, rs1: bus.in_rs1, rs2: bus.in_rs2,
                        rd: bus.in_rd, f3: bus.in_funct3, imm: bus.in_imm,
                        addr: m_ptr, due: cyc + 2});
          m_ptr   = m_ptr + 8'd1;
          m_count = m_count + 1;
        end else if (m_err == 0) begin
          m_err  = 1;
          m_code = code;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [2:0] f, input logic [31:0] imm);
    bus.in_valid    = 1'b1;
    bus.in_enc_type = t;
    bus.in_rs1      = a;
    bus.in_rs2      = b;
    bus.in_rd       = d;
    bus.in_funct3   = f;
    bus.in_imm      = imm;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    m_ptr   = 8'd0;
    m_err   = 0;
    m_code  = 0;
    m_count = 0;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int nd);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.done) nd++;
    end
  endtask

  // Single request, then look at the write slot two cycles after the offer.
  task automatic one_shot(input logic [2:0] t, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic [31:0] imm);
    set_req(t, a, b, d, 3'd0, imm);
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rnd_imm();
    int v;
    int edges[8];
    edges = '{4094, -4096, 4096, -4098, 1048574, -1048576, 1048576, -1048578};
    case ($urandom_range(0, 5))
      0: v = int'($urandom_range(0, 4095)) * 2 - 4096;
      1: v = int'($urandom_range(0, 1048575)) * 2 - 1048576;
      2: v = edges[$urandom_range(0, 7)];
      3: v = int'($urandom);
      4: v = int'($urandom_range(0, 200)) * 2 - 200;
      default: v = int'($urandom_range(0, 100)) * 2 - 99;
    endcase
    return 32'(v);
  endfunction

  initial begin
    int          nd;
    int          k;
    logic [2:0]  t;
    bus.start = 0; bus.finish = 0; bus.in_valid = 0; bus.in_enc_type = 0;
    bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0; bus.in_funct3 = 0; bus.in_imm = 0;
    bus2.start = 0; bus2.finish = 0; bus2.in_valid = 0; bus2.in_enc_type = 0;
    bus2.in_rs1 = 0; bus2.in_rs2 = 0; bus2.in_rd = 0; bus2.in_funct3 = 0; bus2.in_imm = 0;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_err_code", 32'(bus.err_code), 0);
    chk("rst_wr_count", 32'(bus.wr_count), 0);
    chk("rst_we", 32'(bus.imem_we), 0);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_busy2", 32'(bus2.busy), 0);

    // Run 1: directed vectors, then randomized traffic.
    do_start();
    chk("run_busy", 32'(bus.busy), 1);
    chk("run_ready", 32'(bus.in_ready), 1);
    one_shot(3'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    chk("b8_we", 32'(bus.imem_we), 1);
    chk("b8_addr", 32'(bus.imem_addr), 0);
    chk("b8_word", bus.imem_wdata, 32'h00208463);
    one_shot(3'd1, 5'd0, 5'd0, 5'd1, 32'd16);
    chk("j16_addr", 32'(bus.imem_addr), 1);
    chk("j16_word", bus.imem_wdata, 32'h010000EF);
    one_shot(3'd1, 5'd0, 5'd0, 5'd0, -32'sd4);
    chk("jm4_addr", 32'(bus.imem_addr), 2);
    chk("jm4_word", bus.imem_wdata, 32'hFFDFF06F);
    one_shot(3'd0, 5'd3, 5'd4, 5'd0, 32'd4096);
    chk("b4096_we", 32'(bus.imem_we), 0);
    chk("b4096_err", 32'(bus.err), 1);
    chk("b4096_code", 32'(bus.err_code), 3);
    one_shot(3'd0, 5'd3, 5'd4, 5'd0, 32'd3);
    chk("b3_we", 32'(bus.imem_we), 0);
    chk("b3_code", 32'(bus.err_code), 3);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        k = int'($urandom_range(0, 9));
        t = (k < 5) ? 3'd0 : (k < 9) ? 3'd1 : 3'($urandom_range(2, 7));
        set_req(t, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rnd_imm());
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.finish   = 1'b1;
    step();
    bus.finish   = 1'b0;
    wait_done(nd);
    chk("r1_done_pulses", nd, 1);
    chk("r1_busy", 32'(bus.busy), 0);
    chk("r1_err", 32'(bus.err), 32'(m_err));
    chk("r1_err_code", 32'(bus.err_code), 32'(m_code));
    chk("r1_wr_count", 32'(bus.wr_count), 32'(m_count));
    chk("r1_drained", 32'(q.size()), 0);

    // Run 2: finish on the same cycle as the last handshake.
    do_start();
    chk("r2_err_clr", 32'(bus.err), 0);
    chk("r2_code_clr", 32'(bus.err_code), 0);
    chk("r2_count_clr", 32'(bus.wr_count), 0);
    set_req(3'd0, 5'd5, 5'd6, 5'd0, 3'd1, -32'sd4096);
    step();
    set_req(3'd1, 5'd0, 5'd0, 5'd7, 3'd0, 32'd1048574);
    step();
    set_req(3'd0, 5'd8, 5'd9, 5'd0, 3'd7, 32'd4094);
    bus.finish = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.finish   = 1'b0;
    wait_done(nd);
    chk("r2_done_pulses", nd, 1);
    chk("r2_wr_count", 32'(bus.wr_count), 3);
    chk("r2_err", 32'(bus.err), 0);

    // Run 3: error priority and first-error latching.
    do_start();
    set_req(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 32'd3);
    step();
    set_req(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 32'd5);
    step();
    set_req(3'd1, 5'd0, 5'd0, 5'd1, 3'd0, 32'd1048576);
    step();
    set_req(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, -32'sd4098);
    bus.finish = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.finish   = 1'b0;
    wait_done(nd);
    chk("r3_err", 32'(bus.err), 1);
    chk("r3_err_code", 32'(bus.err_code), 1);
    chk("r3_model_code", 32'(bus.err_code), 32'(m_code));
    chk("r3_wr_count", 32'(bus.wr_count), 0);

    // Reset while requests are in flight.
    do_start();
    set_req(3'd0, 5'd1, 5'd2, 5'd0, 3'd0, 32'd8);
    step();
    set_req(3'd1, 5'd0, 5'd0, 5'd1, 3'd0, 32'd16);
    rst = 1'b1;
    step();
    chk("rst_mid_we0", 32'(bus.imem_we), 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_we", 32'(bus.imem_we), 0);
    end
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_count", 32'(bus.wr_count), 0);

    // Capacity limit on the 4-word instance.
    bus2.start = 1'b1;
    step();
    bus2.start = 1'b0;
    k  = 0;
    nd = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 5) begin
        bus2.in_valid = 1'b1;
        bus2.in_imm   = 32'(2 * i);
        chk("cap_ready", 32'(bus2.in_ready), 32'(i < 4));
      end else begin
        bus2.in_valid = 1'b0;
      end
      step();
      if (bus2.imem_we) begin
        chk("cap_addr", 32'(bus2.imem_addr), 32'(k));
        k++;
      end
      if (bus2.done) nd++;
    end
    chk("cap_writes", k, 4);
    chk("cap_done", nd, 1);
    chk("cap_wr_count", 32'(bus2.wr_count), 4);
    chk("cap_busy", 32'(bus2.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
